// File: rtl/reg_checkpoint_unit_if.sv
// -----------------------------------------------------------------------------
// reg_checkpoint_unit_if
// Bundles the signals between the checkpoint unit, the decode/branch logic and
// the register file.
//   slave  modport : the checkpoint unit itself
//   master modport : the surrounding pipeline (decode, branch unit, reg_file)
// Signals:
//   regs_in / wb_*        live register array plus same-cycle write-back
//   take_snapshot         capture request, answered by snapshot_accept/_id
//   release_oldest        oldest branch resolved correctly
//   mispredict            oldest branch resolved wrong, restore its slot
//   rf_done               register file finished loading the restore image
//   recover_snapshot      one-cycle load strobe, data on regs_snapshot
//   recovery_done_ack     one-cycle close of the recovery handshake
//   busy / full / count   status
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface reg_checkpoint_unit_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0][DATA_WIDTH-1:0] regs_in;
  logic                        wb_uses_rw;
  logic [4:0]                  wb_rw_addr;
  logic [DATA_WIDTH-1:0]       wb_rw_data;
  logic                        take_snapshot;
  logic                        snapshot_accept;
  logic [PTR_W-1:0]            snapshot_id;
  logic                        release_oldest;
  logic                        mispredict;
  logic                        rf_done;
  logic                        recover_snapshot;
  logic [31:0][DATA_WIDTH-1:0] regs_snapshot;
  logic                        recovery_done_ack;
  logic                        busy;
  logic                        full;
  logic [PTR_W:0]              count;

  modport slave (
    input  regs_in, wb_uses_rw, wb_rw_addr, wb_rw_data,
    input  take_snapshot, release_oldest, mispredict, rf_done,
    output snapshot_accept, snapshot_id, recover_snapshot, regs_snapshot,
    output recovery_done_ack, busy, full, count
  );

  modport master (
    output regs_in, wb_uses_rw, wb_rw_addr, wb_rw_data,
    output take_snapshot, release_oldest, mispredict, rf_done,
    input  snapshot_accept, snapshot_id, recover_snapshot, regs_snapshot,
    input  recovery_done_ack, busy, full, count
  );
endinterface

// File: rtl/reg_checkpoint_unit.sv
// -----------------------------------------------------------------------------
// reg_checkpoint_unit
// Circular store of DEPTH architectural register-file snapshots, one per
// in-flight predicted branch. The oldest checkpoint (rd_ptr) is freed on a
// correct resolution or restored into the register file on a misprediction.
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   reg_checkpoint_unit_if.slave (see interface header for members)
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module reg_checkpoint_unit #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_checkpoint_unit_if.slave   bus
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef logic [31:0][DATA_WIDTH-1:0] regs_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTORE = 2'd1,
    ST_WAIT    = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  // Image of the register file after the current edge: live array with the
  // pending write-back folded in; x0 is hard-wired to zero.
  function automatic regs_t merge_wb(
    input regs_t                 live,
    input logic                  uses,
    input logic [4:0]            addr,
    input logic [DATA_WIDTH-1:0] data
  );
    regs_t m;
    m = live;
    if (uses && (addr != 5'd0)) begin
      m[addr] = data;
    end else begin
      m = m;
    end
    m[0] = {DATA_WIDTH{1'b0}};
    return m;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W-1:0] wr_ptr_next_s;
  logic [PTR_W-1:0] rd_ptr_next_s;
  logic [PTR_W:0]   count_next_s;
  logic             full_r;
  logic             busy_r;
  logic             recover_r;
  logic             ack_r;
  regs_t            snap_r;
  regs_t            merged_s;
  regs_t            slot_r [DEPTH];
  logic             accept_s;
  logic             release_s;
  logic             restore_s;

  // Request qualification: mispredict outranks take and release, and nothing
  // is acted on while a recovery is running.
  always_comb begin
    merged_s  = merge_wb(bus.regs_in, bus.wb_uses_rw, bus.wb_rw_addr, bus.wb_rw_data);
    accept_s  = bus.take_snapshot & ~full_r & ~busy_r & ~bus.mispredict;
    release_s = bus.release_oldest & (count_r != '0) & ~busy_r & ~bus.mispredict;
    restore_s = (state_r == ST_IDLE) & bus.mispredict & (count_r != '0);
  end

  // Pointer and occupancy update; a restore flushes every younger checkpoint.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    count_next_s  = count_r;
    if (restore_s) begin
      wr_ptr_next_s = '0;
      rd_ptr_next_s = '0;
      count_next_s  = '0;
    end else begin
      if (accept_s) begin
        wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (release_s) begin
        rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      case ({accept_s, release_s})
        2'b10:   count_next_s = count_r + (PTR_W+1)'(1);
        2'b01:   count_next_s = count_r - (PTR_W+1)'(1);
        default: count_next_s = count_r;
      endcase
    end
  end

  // Recovery sequencing: restore strobe, wait for the register file, ack.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (restore_s) begin
          state_next_s = ST_RESTORE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RESTORE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.rf_done) begin
          state_next_s = ST_ACK;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_ACK:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Control state and registered outputs; strobes are decoded from the next
  // state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      full_r    <= 1'b0;
      busy_r    <= 1'b0;
      recover_r <= 1'b0;
      ack_r     <= 1'b0;
      snap_r    <= '0;
    end else begin
      state_r   <= state_next_s;
      wr_ptr_r  <= wr_ptr_next_s;
      rd_ptr_r  <= rd_ptr_next_s;
      count_r   <= count_next_s;
      full_r    <= (count_next_s == FULL_CNT);
      busy_r    <= (state_next_s != ST_IDLE);
      recover_r <= (state_next_s == ST_RESTORE);
      ack_r     <= (state_next_s == ST_ACK);
      // Loaded only when leaving IDLE, so it holds through RESTORE..ACK.
      if (restore_s) begin
        snap_r <= slot_r[rd_ptr_r];
      end else begin
        snap_r <= snap_r;
      end
    end
  end

  // Checkpoint storage; contents of free slots are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (accept_s && !rst) begin
      slot_r[wr_ptr_r] <= merged_s;
    end
  end

  assign bus.snapshot_accept   = accept_s;
  assign bus.snapshot_id       = wr_ptr_r;
  assign bus.recover_snapshot  = recover_r;
  assign bus.regs_snapshot     = snap_r;
  assign bus.recovery_done_ack = ack_r;
  assign bus.busy              = busy_r;
  assign bus.full              = full_r;
  assign bus.count             = count_r;

endmodule

// File: tb/tb_reg_checkpoint_unit.sv
// -----------------------------------------------------------------------------
// tb_reg_checkpoint_unit
// Directed stimulus with a scoreboard: expected snapshot ids, restore images
// and acks are queued when stimulus is issued; a negedge monitor pops and
// compares whenever the DUT presents the corresponding strobe.
// -----------------------------------------------------------------------------
module tb_reg_checkpoint_unit;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  typedef logic [31:0][DW-1:0] img_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_checkpoint_unit_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

  reg_checkpoint_unit #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   errors = 0;
  int   checks = 0;
  logic [1:0] id_q [$];
  img_t       rec_q [$];
  int   acks_pending = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic img_t make_img(input logic [31:0] base, input int wb_addr, input logic [31:0] wb_data);
    img_t m;
    for (int i = 0; i < 32; i++) m[i] = base + 32'(i);
    if (wb_addr > 0) m[wb_addr] = wb_data;
    m[0] = 32'h0;
    return m;
  endfunction

  task automatic set_regs(input logic [31:0] base);
    for (int i = 0; i < 32; i++) bus.regs_in[i] = base + 32'(i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe the DUT raises must match a queued expectation.
  always @(negedge clk) begin
    if (bus.snapshot_accept === 1'b1) begin
      if (id_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_accept: got id %0d expected no accept", bus.snapshot_id);
      end else begin
        logic [1:0] e_id;
        e_id = id_q.pop_front();
        check("snapshot_id", 64'(bus.snapshot_id), 64'(e_id));
      end
    end
    if (bus.recover_snapshot === 1'b1) begin
      if (rec_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_recover: got recover_snapshot=1 expected 0");
      end else begin
        img_t e_img;
        e_img = rec_q.pop_front();
        checks++;
        if (bus.regs_snapshot !== e_img) begin
          errors++;
          for (int k = 0; k < 32; k++) begin
            if (bus.regs_snapshot[k] !== e_img[k]) begin
              $display("FAIL regs_snapshot word %0d: got %h expected %h", k, bus.regs_snapshot[k], e_img[k]);
              break;
            end
          end
        end
        check("count_at_restore", 64'(bus.count), 64'(0));
        check("busy_at_restore", 64'(bus.busy), 64'(1));
      end
    end
    if (bus.recovery_done_ack === 1'b1) begin
      checks++;
      if (acks_pending == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got recovery_done_ack=1 expected 0");
      end else begin
        acks_pending--;
      end
    end
  end

  // Drives the register-file side of a recovery; entered in the RESTORE cycle.
  task automatic do_recover(input int extra, input bit poke);
    check("recover_t1", 64'(bus.recover_snapshot), 64'(1));
    check("busy_t1", 64'(bus.busy), 64'(1));
    tick();
    check("recover_t2", 64'(bus.recover_snapshot), 64'(0));
    check("busy_t2", 64'(bus.busy), 64'(1));
    for (int i = 0; i < extra; i++) begin
      if (poke) begin
        bus.take_snapshot = 1'b1;
        bus.mispredict    = 1'b1;
        #1;
        check("take_during_busy", 64'(bus.snapshot_accept), 64'(0));
      end
      tick();
      bus.take_snapshot = 1'b0;
      bus.mispredict    = 1'b0;
      check("busy_wait", 64'(bus.busy), 64'(1));
      check("ack_wait", 64'(bus.recovery_done_ack), 64'(0));
    end
    bus.rf_done = 1'b1;
    tick();
    bus.rf_done = 1'b0;
    check("ack_pulse", 64'(bus.recovery_done_ack), 64'(1));
    check("busy_ack", 64'(bus.busy), 64'(1));
    tick();
    check("busy_released", 64'(bus.busy), 64'(0));
    check("ack_single", 64'(bus.recovery_done_ack), 64'(0));
    check("count_after", 64'(bus.count), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.regs_in        = '0;
    bus.wb_uses_rw     = 1'b0;
    bus.wb_rw_addr     = 5'd0;
    bus.wb_rw_data     = 32'h0;
    bus.take_snapshot  = 1'b0;
    bus.release_oldest = 1'b0;
    bus.mispredict     = 1'b0;
    bus.rf_done        = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_count", 64'(bus.count), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_full", 64'(bus.full), 64'(0));
    check("reset_snapshot_zero", 64'(bus.regs_snapshot == '0), 64'(1));
    check("reset_recover", 64'(bus.recover_snapshot), 64'(0));
    check("reset_ack", 64'(bus.recovery_done_ack), 64'(0));

    // Capture with write-back merge and x0 forcing.
    set_regs(32'h0);
    bus.regs_in[0]     = 32'hFFFF_0000;
    bus.take_snapshot  = 1'b1;
    bus.wb_uses_rw     = 1'b1;
    bus.wb_rw_addr     = 5'd5;
    bus.wb_rw_data     = 32'hDEAD_BEEF;
    id_q.push_back(2'd0);
    tick();
    bus.take_snapshot  = 1'b0;
    bus.wb_uses_rw     = 1'b0;
    check("count_one", 64'(bus.count), 64'(1));
    set_regs(32'h100);
    bus.mispredict = 1'b1;
    rec_q.push_back(make_img(32'h0, 5, 32'hDEAD_BEEF));
    acks_pending++;
    tick();
    bus.mispredict = 1'b0;
    do_recover(0, 1'b0);

    // Fill, overflow, release, release+take wrap.
    for (int k = 0; k < 4; k++) begin
      set_regs(32'h1000 * 32'(k + 1));
      bus.take_snapshot = 1'b1;
      id_q.push_back(2'(k));
      tick();
      bus.take_snapshot = 1'b0;
    end
    check("count_full", 64'(bus.count), 64'(4));
    check("full_set", 64'(bus.full), 64'(1));
    set_regs(32'h5000);
    bus.take_snapshot = 1'b1;
    #1;
    check("overflow_accept", 64'(bus.snapshot_accept), 64'(0));
    tick();
    bus.take_snapshot = 1'b0;
    check("overflow_count", 64'(bus.count), 64'(4));
    bus.release_oldest = 1'b1;
    tick();
    bus.release_oldest = 1'b0;
    check("release_count", 64'(bus.count), 64'(3));
    check("release_full", 64'(bus.full), 64'(0));
    set_regs(32'h6000);
    bus.take_snapshot  = 1'b1;
    bus.release_oldest = 1'b1;
    id_q.push_back(2'd0);
    tick();
    bus.take_snapshot  = 1'b0;
    bus.release_oldest = 1'b0;
    check("take_release_count", 64'(bus.count), 64'(3));
    set_regs(32'h7000);
    bus.take_snapshot = 1'b1;
    id_q.push_back(2'd1);
    tick();
    bus.take_snapshot = 1'b0;
    check("refill_full", 64'(bus.full), 64'(1));

    // Mispredict with take in the same cycle; oldest is slot 2 (base 0x3000).
    set_regs(32'h8000);
    bus.take_snapshot = 1'b1;
    bus.mispredict    = 1'b1;
    #1;
    check("take_vs_mispredict", 64'(bus.snapshot_accept), 64'(0));
    rec_q.push_back(make_img(32'h3000, 0, 32'h0));
    acks_pending++;
    tick();
    bus.take_snapshot = 1'b0;
    bus.mispredict    = 1'b0;
    do_recover(3, 1'b1);

    // Ordering: A, B, release A, mispredict restores B.
    set_regs(32'hA000);
    bus.take_snapshot = 1'b1;
    id_q.push_back(2'd0);
    tick();
    set_regs(32'hB000);
    id_q.push_back(2'd1);
    tick();
    bus.take_snapshot = 1'b0;
    check("order_count", 64'(bus.count), 64'(2));
    bus.release_oldest = 1'b1;
    tick();
    bus.release_oldest = 1'b0;
    bus.mispredict = 1'b1;
    rec_q.push_back(make_img(32'hB000, 0, 32'h0));
    acks_pending++;
    tick();
    bus.mispredict = 1'b0;
    do_recover(0, 1'b0);

    // Mispredict with nothing in flight.
    bus.mispredict = 1'b1;
    tick();
    bus.mispredict = 1'b0;
    check("empty_mispredict_recover", 64'(bus.recover_snapshot), 64'(0));
    check("empty_mispredict_busy", 64'(bus.busy), 64'(0));

    // Reset while waiting for rf_done.
    set_regs(32'hC000);
    bus.take_snapshot = 1'b1;
    id_q.push_back(2'd0);
    tick();
    bus.take_snapshot = 1'b0;
    bus.mispredict = 1'b1;
    rec_q.push_back(make_img(32'hC000, 0, 32'h0));
    tick();
    bus.mispredict = 1'b0;
    tick();
    check("wait_busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wait_busy", 64'(bus.busy), 64'(0));
    check("rst_wait_count", 64'(bus.count), 64'(0));
    check("rst_wait_snapshot", 64'(bus.regs_snapshot == '0), 64'(1));
    repeat (3) tick();
    check("rst_wait_idle", 64'(bus.busy), 64'(0));

    check("id_q_drained", 64'(id_q.size()), 64'(0));
    check("rec_q_drained", 64'(rec_q.size()), 64'(0));
    check("acks_drained", 64'(acks_pending), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
